// File: rtl/dbguart_pkg.sv
// -----------------------------------------------------------------------------
// dbguart_pkg
// Shared definitions for the debug UART register bank:
//   - per-channel register offsets (word index, addr[4:2])
//   - rsize encodings
//   - INT_STAT bit indices
//   - be_from_size():  byte enables from access size and byte lane
//   - wdata_align():   shifts right-justified write data into its byte lane
// -----------------------------------------------------------------------------
package dbguart_pkg;

    // Register word offsets inside a 32-byte channel window
    localparam logic [2:0] CTRL_OFF     = 3'd0;
    localparam logic [2:0] BAUD_OFF     = 3'd1;
    localparam logic [2:0] STATUS_OFF   = 3'd2;
    localparam logic [2:0] INT_STAT_OFF = 3'd3;
    localparam logic [2:0] INT_EN_OFF   = 3'd4;
    localparam logic [2:0] TXDATA_OFF   = 3'd5;
    localparam logic [2:0] RXDATA_OFF   = 3'd6;
    localparam logic [2:0] INFO_OFF     = 3'd7;

    // rsize encodings; every other code is a word access
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;

    // INT_STAT layout: [3:0] external events, [4] TX overflow
    localparam int INT_W       = 5;
    localparam int INT_EVT_W   = 4;
    localparam int INT_OVF_BIT = 4;

    function automatic logic [3:0] be_from_size(input logic [1:0] rsize,
                                                input logic [1:0] lane);
        logic [3:0] be;
        case (rsize)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] wdata_align(input logic [1:0]  rsize,
                                                input logic [1:0]  lane,
                                                input logic [31:0] wrdata);
        logic [31:0] d;
        case (rsize)
            SZ_BYTE: d = wrdata << {lane, 3'b000};
            SZ_HALF: d = lane[1] ? (wrdata << 16) : wrdata;
            default: d = wrdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dbguart_chan_regs.sv
// -----------------------------------------------------------------------------
// dbguart_chan_regs
// Register set of one UART channel: CTRL, BAUD, TX holding register,
// sticky W1C INT_STAT, INT_EN, irq, and the combinational read view of all
// eight offsets (registered by the parent).
//
// Configuration macro: DBGUART_REGBANK_INTR_EN
//   defined   -> INT_STAT / INT_EN / irq implemented
//   undefined -> INT_STAT / INT_EN read 0, writes ignored, irq tied 0
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   wr_en             write strobe for this channel (already decoded)
//   off, be, wdata    register offset, byte enables [1:0], lane-aligned data
//   status            read-only status word
//   tx_data/tx_valid  TX handoff to the UART core, tx_ready from the core
//   rx_data/rx_valid  RX data presented by the UART core
//   evt               single-cycle event pulses into INT_STAT[3:0]
//   rd_data           combinational read data for offset 'off'
//   ctrl, baud        register outputs
//   irq               registered interrupt level
//
// TX handshake: a byte transfers on every cycle where tx_valid and tx_ready
// are both 1 at the clock edge; tx_valid, once set, holds with stable
// tx_data until that transfer.
// -----------------------------------------------------------------------------
module dbguart_chan_regs
    import dbguart_pkg::*;
#(
    parameter int          NCH      = 2,
    parameter int          CH_IDX   = 0,
    parameter logic [7:0]  CTRL_RST = 8'h50,
    parameter logic [15:0] BAUD_RST = 16'h6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [2:0]  off,
    input  logic [1:0]  be,
    input  logic [15:0] wdata,
    input  logic [31:0] status,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic [3:0]  evt,
    output logic [31:0] rd_data,
    output logic [7:0]  ctrl,
    output logic [15:0] baud,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        irq
);

    logic [7:0]  ctrl_q, ctrl_d;
    logic [15:0] baud_q, baud_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        tx_fire, tx_wr, tx_ovf;
    logic [INT_W-1:0] int_stat_rd, int_en_rd;

    always_comb begin
        ctrl_d     = ctrl_q;
        baud_d     = baud_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_ovf     = 1'b0;
        tx_fire    = tx_valid_q & tx_ready;
        tx_wr      = wr_en && (off == TXDATA_OFF) && be[0];

        if (wr_en && (off == CTRL_OFF) && be[0]) ctrl_d = wdata[7:0];
        if (wr_en && (off == BAUD_OFF)) begin
            if (be[0]) baud_d[7:0]  = wdata[7:0];
            if (be[1]) baud_d[15:8] = wdata[15:8];
        end

        // The holding register is free when empty or draining this cycle,
        // so a write coinciding with the handoff refills it seamlessly.
        if (tx_wr && (!tx_valid_q || tx_fire)) begin
            tx_data_d  = wdata[7:0];
            tx_valid_d = 1'b1;
        end else if (tx_fire) begin
            tx_valid_d = 1'b0;
        end else if (tx_wr) begin
            tx_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q     <= CTRL_RST;
            baud_q     <= BAUD_RST;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            baud_q     <= baud_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

`ifdef DBGUART_REGBANK_INTR_EN
    logic [INT_W-1:0] int_stat_q, int_stat_d;
    logic [INT_W-1:0] int_en_q, int_en_d;
    logic             irq_q, irq_d;
    logic [INT_W-1:0] int_clr, int_set;

    always_comb begin
        int_en_d = int_en_q;
        int_clr  = '0;
        if (wr_en && (off == INT_EN_OFF) && be[0])   int_en_d = wdata[INT_W-1:0];
        if (wr_en && (off == INT_STAT_OFF) && be[0]) int_clr  = wdata[INT_W-1:0];
        int_set = {tx_ovf, evt};
        // set is OR-ed after the clear so a coincident event is never lost
        int_stat_d = (int_stat_q & ~int_clr) | int_set;
        // built from next-state so irq moves on the same edge as INT_STAT/INT_EN
        irq_d = |(int_stat_d & int_en_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            int_stat_q <= '0;
            int_en_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            int_stat_q <= int_stat_d;
            int_en_q   <= int_en_d;
            irq_q      <= irq_d;
        end
    end

    assign int_stat_rd = int_stat_q;
    assign int_en_rd   = int_en_q;
    assign irq         = irq_q;
`else
    logic unused_intr;
    assign unused_intr = ^{evt, tx_ovf};
    assign int_stat_rd = '0;
    assign int_en_rd   = '0;
    assign irq         = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        case (off)
            CTRL_OFF:     rd_data = {24'b0, ctrl_q};
            BAUD_OFF:     rd_data = {16'b0, baud_q};
            STATUS_OFF:   rd_data = status;
            INT_STAT_OFF: rd_data = {{(32-INT_W){1'b0}}, int_stat_rd};
            INT_EN_OFF:   rd_data = {{(32-INT_W){1'b0}}, int_en_rd};
            TXDATA_OFF:   rd_data = '0;
            RXDATA_OFF:   rd_data = {rx_valid, 23'b0, rx_data};
            INFO_OFF:     rd_data = {16'b0, 8'(NCH), 8'(CH_IDX)};
            default:      rd_data = '0;
        endcase
    end

    assign ctrl     = ctrl_q;
    assign baud     = baud_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;

endmodule

// File: rtl/dbguart_regbank.sv
// -----------------------------------------------------------------------------
// dbguart_regbank
// Multi-channel register bank for the debug UART subsystem. Each channel owns
// a 32-byte window (ch = addr[ADDR_W-1:5], offset = addr[4:2]). Reads are
// registered: a read sampled in cycle N returns rdata/rvalid in cycle N+1,
// together with the rx_pop pulse for an RXDATA read of a valid byte.
//
// Configuration macro: DBGUART_REGBANK_INTR_EN (interrupt logic, see
// dbguart_chan_regs).
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   rsel, rwrite, rsize, addr,
//   wrdata                          bus request
//   rdata, rvalid                   registered read response
//   uart_control, baudrate          per-channel CTRL / BAUD (packed by channel)
//   status                          per-channel read-only status words
//   tx_data, tx_valid, tx_ready     per-channel TX handoff
//   rx_data, rx_valid, rx_pop       per-channel RX handoff
//   evt                             per-channel event pulses (4 per channel)
//   irq                             per-channel interrupt level
// -----------------------------------------------------------------------------
module dbguart_regbank
    import dbguart_pkg::*;
#(
    parameter int          NCH      = 2,
    parameter int          ADDR_W   = 8,
    parameter logic [7:0]  CTRL_RST = 8'h50,
    parameter logic [15:0] BAUD_RST = 16'h6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rsel,
    input  logic                rwrite,
    input  logic [1:0]          rsize,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [31:0]         wrdata,
    output logic [31:0]         rdata,
    output logic                rvalid,
    output logic [NCH*8-1:0]    uart_control,
    output logic [NCH*16-1:0]   baudrate,
    input  logic [NCH*32-1:0]   status,
    output logic [NCH*8-1:0]    tx_data,
    output logic [NCH-1:0]      tx_valid,
    input  logic [NCH-1:0]      tx_ready,
    input  logic [NCH*8-1:0]    rx_data,
    input  logic [NCH-1:0]      rx_valid,
    output logic [NCH-1:0]      rx_pop,
    input  logic [NCH*4-1:0]    evt,
    output logic [NCH-1:0]      irq
);

    localparam int CH_W = ADDR_W - 5;

    logic [CH_W-1:0] ch;
    logic [2:0]      off;
    logic [3:0]      be;
    logic [31:0]     wdata_al;
    logic            ch_valid;
    logic            wr_req, rd_req;
    logic [NCH-1:0]  wr_en;
    logic [31:0]     chan_rd [NCH];
    logic [31:0]     rd_mux;

    logic [31:0]     rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic [NCH-1:0]  rx_pop_q, rx_pop_d;

    assign ch       = addr[ADDR_W-1:5];
    assign off      = addr[4:2];
    assign be       = be_from_size(rsize, addr[1:0]);
    assign wdata_al = wdata_align(rsize, addr[1:0], wrdata);
    assign ch_valid = int'(ch) < NCH;
    assign wr_req   = rsel & rwrite;
    assign rd_req   = rsel & ~rwrite;

    // No register is wider than 16 bits, so the upper lanes are never consumed
    logic unused_lanes;
    assign unused_lanes = ^{be[3:2], wdata_al[31:16]};

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        assign wr_en[c] = wr_req && ch_valid && (ch == CH_W'(c));

        dbguart_chan_regs #(
            .NCH      (NCH),
            .CH_IDX   (c),
            .CTRL_RST (CTRL_RST),
            .BAUD_RST (BAUD_RST)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_en[c]),
            .off      (off),
            .be       (be[1:0]),
            .wdata    (wdata_al[15:0]),
            .status   (status[c*32 +: 32]),
            .tx_ready (tx_ready[c]),
            .rx_data  (rx_data[c*8 +: 8]),
            .rx_valid (rx_valid[c]),
            .evt      (evt[c*4 +: 4]),
            .rd_data  (chan_rd[c]),
            .ctrl     (uart_control[c*8 +: 8]),
            .baud     (baudrate[c*16 +: 16]),
            .tx_data  (tx_data[c*8 +: 8]),
            .tx_valid (tx_valid[c]),
            .irq      (irq[c])
        );
    end

    always_comb begin
        rd_mux   = '0;
        rx_pop_d = '0;
        for (int c = 0; c < NCH; c++) begin
            if (ch_valid && (ch == CH_W'(c))) begin
                rd_mux      = chan_rd[c];
                // pop only a byte actually present, so an empty read is harmless
                rx_pop_d[c] = rd_req && (off == RXDATA_OFF) && rx_valid[c];
            end
        end
        // out-of-range channels fall through with rd_mux = 0
        rdata_d  = rd_req ? rd_mux : rdata_q;
        rvalid_d = rd_req;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rx_pop_q <= '0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rx_pop_q <= rx_pop_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign rx_pop = rx_pop_q;

endmodule

// File: tb/tb_dbguart_regbank.sv
// -----------------------------------------------------------------------------
// tb_dbguart_regbank
// Directed bench for dbguart_regbank (NCH=2, ADDR_W=8). Expected values are
// hand-computed; interrupt-related expectations depend on whether
// DBGUART_REGBANK_INTR_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_dbguart_regbank;

    localparam int NCH    = 2;
    localparam int ADDR_W = 8;
`ifdef DBGUART_REGBANK_INTR_EN
    localparam bit INTR = 1'b1;
`else
    localparam bit INTR = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              rsel, rwrite;
    logic [1:0]        rsize;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wrdata;
    logic [31:0]       rdata;
    logic              rvalid;
    logic [15:0]       uart_control;
    logic [31:0]       baudrate;
    logic [63:0]       status;
    logic [15:0]       tx_data;
    logic [1:0]        tx_valid, tx_ready;
    logic [15:0]       rx_data;
    logic [1:0]        rx_valid, rx_pop;
    logic [7:0]        evt;
    logic [1:0]        irq;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] rd_d;
    logic        rd_v;
    logic [1:0]  rd_p;

    dbguart_regbank #(
        .NCH      (NCH),
        .ADDR_W   (ADDR_W),
        .CTRL_RST (8'h50),
        .BAUD_RST (16'h6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rsel         (rsel),
        .rwrite       (rwrite),
        .rsize        (rsize),
        .addr         (addr),
        .wrdata       (wrdata),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .uart_control (uart_control),
        .baudrate     (baudrate),
        .status       (status),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_pop       (rx_pop),
        .evt          (evt),
        .irq          (irq)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [1:0] sz, input logic [31:0] d);
        @(negedge clk);
        rsel = 1'b1; rwrite = 1'b1; addr = a; rsize = sz; wrdata = d;
        @(posedge clk); #1;
        rsel = 1'b0; rwrite = 1'b0;
    endtask

    // returns the response registered at the sampling edge (cycle N+1)
    task automatic bus_read(input logic [7:0] a, output logic [31:0] d,
                            output logic v, output logic [1:0] p);
        @(negedge clk);
        rsel = 1'b1; rwrite = 1'b0; addr = a; rsize = 2'd0; wrdata = '0;
        @(posedge clk); #1;
        rsel = 1'b0;
        d = rdata; v = rvalid; p = rx_pop;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        bus_read(a, rd_d, rd_v, rd_p);
        chk(tag, rd_d, exp);
        chk({tag, "_rvalid"}, {31'b0, rd_v}, 32'd1);
    endtask

    logic [7:0]  ra [12];
    logic [31:0] re [12];

    initial begin
        rst_n = 1'b0; rsel = 1'b0; rwrite = 1'b0; rsize = 2'd0; addr = '0; wrdata = '0;
        status = {32'h1234_5678, 32'hCAFE_0001};
        tx_ready = 2'b00; rx_data = '0; rx_valid = 2'b00; evt = '0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata",    rdata, 32'h0);
        chk("rst_rvalid",   {31'b0, rvalid}, 32'h0);
        chk("rst_irq",      {30'b0, irq}, 32'h0);
        chk("rst_tx_valid", {30'b0, tx_valid}, 32'h0);
        chk("rst_rx_pop",   {30'b0, rx_pop}, 32'h0);
        chk("rst_ctrl",     {16'b0, uart_control}, 32'h5050);
        chk("rst_baud",     baudrate, 32'h0006_0006);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- read map of ch0 / ch1 after reset ----
        ra[0] = 8'h00; re[0] = 32'h50;
        ra[1] = 8'h04; re[1] = 32'h6;
        ra[2] = 8'h08; re[2] = 32'hCAFE_0001;
        ra[3] = 8'h0C; re[3] = 32'h0;
        ra[4] = 8'h10; re[4] = 32'h0;
        ra[5] = 8'h14; re[5] = 32'h0;
        ra[6] = 8'h18; re[6] = 32'h0;
        ra[7] = 8'h1C; re[7] = 32'h0000_0200;
        ra[8] = 8'h20; re[8] = 32'h50;
        ra[9] = 8'h24; re[9] = 32'h6;
        ra[10] = 8'h28; re[10] = 32'h1234_5678;
        ra[11] = 8'h3C; re[11] = 32'h0000_0201;
        for (int i = 0; i < 12; i++) begin
            rd_chk($sformatf("map_rd_%02h", ra[i]), ra[i], re[i]);
        end
        chk("map_irq", {30'b0, irq}, 32'h0);

        // ---- byte lanes ----
        bus_write(8'h25, 2'd1, 32'h0000_00AB);
        chk("baud1_byte_lane1", baudrate, 32'hAB06_0006);
        rd_chk("baud1_byte_rd", 8'h24, 32'h0000_AB06);
        bus_write(8'h26, 2'd2, 32'h0000_BEEF);   // upper half: beyond BAUD width
        chk("baud1_half_hi_ignored", baudrate, 32'hAB06_0006);
        bus_write(8'h24, 2'd0, 32'h1234_5678);
        chk("baud1_word", baudrate, 32'h5678_0006);
        bus_write(8'h20, 2'd1, 32'h0000_003C);
        chk("ctrl1_byte", {16'b0, uart_control}, 32'h3C50);
        bus_write(8'h03, 2'd1, 32'h0000_00FF);   // lane 3 of CTRL0: nothing enabled
        chk("ctrl0_lane3_ignored", {16'b0, uart_control}, 32'h3C50);

        // ---- TX holding register ----
        bus_write(8'h14, 2'd0, 32'h41);
        chk("tx_first_valid", {30'b0, tx_valid}, 32'h1);
        chk("tx_first_data",  {24'b0, tx_data[7:0]}, 32'h41);
        bus_write(8'h14, 2'd0, 32'h42);
        chk("tx_ovf_valid", {30'b0, tx_valid}, 32'h1);
        chk("tx_ovf_data",  {24'b0, tx_data[7:0]}, 32'h41);
        rd_chk("tx_ovf_int_stat", 8'h0C, INTR ? 32'h10 : 32'h0);
        rd_chk("txdata_reads_0", 8'h14, 32'h0);
        bus_write(8'h0C, 2'd0, 32'h10);          // W1C overflow
        rd_chk("ovf_cleared", 8'h0C, 32'h0);
        @(negedge clk);
        tx_ready = 2'b01;
        @(posedge clk); #1;
        chk("tx_handoff_clears", {30'b0, tx_valid}, 32'h0);
        bus_write(8'h14, 2'd0, 32'h43);
        chk("tx_refill_valid", {30'b0, tx_valid}, 32'h1);
        chk("tx_refill_data",  {24'b0, tx_data[7:0]}, 32'h43);
        bus_write(8'h14, 2'd0, 32'h44);          // coincides with handoff of 0x43
        chk("tx_same_cycle_valid", {30'b0, tx_valid}, 32'h1);
        chk("tx_same_cycle_data",  {24'b0, tx_data[7:0]}, 32'h44);
        rd_chk("tx_same_cycle_no_ovf", 8'h0C, 32'h0);
        chk("tx_drained", {30'b0, tx_valid}, 32'h0);
        @(negedge clk);
        tx_ready = 2'b00;

        // ---- RX popping read on ch1 ----
        rx_valid = 2'b10; rx_data = 16'h5A00;
        bus_read(8'h38, rd_d, rd_v, rd_p);
        chk("rx_rdata",  rd_d, 32'h8000_005A);
        chk("rx_rvalid", {31'b0, rd_v}, 32'h1);
        chk("rx_pop",    {30'b0, rd_p}, 32'h2);
        rx_valid = 2'b00; rx_data = 16'h0;
        @(posedge clk); #1;
        chk("rx_pop_single", {30'b0, rx_pop}, 32'h0);
        chk("rx_rdata_held", rdata, 32'h8000_005A);
        bus_read(8'h38, rd_d, rd_v, rd_p);
        chk("rx_empty_rdata", rd_d, 32'h0);
        chk("rx_empty_no_pop", {30'b0, rd_p}, 32'h0);

        // ---- interrupts ----
        bus_write(8'h10, 2'd0, 32'h1);
        chk("inten_no_irq", {30'b0, irq}, 32'h0);
        rd_chk("inten_rd", 8'h10, INTR ? 32'h1 : 32'h0);
        @(negedge clk);
        rsel = 1'b1; rwrite = 1'b1; addr = 8'h0C; rsize = 2'd0; wrdata = 32'h1;
        evt = 8'b0000_0001;
        @(posedge clk); #1;
        rsel = 1'b0; rwrite = 1'b0; evt = '0;
        chk("set_wins_irq", {30'b0, irq}, INTR ? 32'h1 : 32'h0);
        rd_chk("set_wins_stat", 8'h0C, INTR ? 32'h1 : 32'h0);
        bus_write(8'h0C, 2'd0, 32'h1);
        chk("w1c_irq_falls", {30'b0, irq}, 32'h0);
        rd_chk("w1c_stat", 8'h0C, 32'h0);
        @(negedge clk);
        evt = 8'b0100_0000;                      // ch1 event 2, ch1 INT_EN = 0
        @(posedge clk); #1;
        evt = '0;
        chk("ch1_evt_masked_irq", {30'b0, irq}, 32'h0);
        rd_chk("ch1_evt_stat", 8'h2C, INTR ? 32'h4 : 32'h0);

        // ---- out-of-range channel ----
        bus_write(8'h40, 2'd0, 32'hFFFF_FFFF);
        chk("oor_ctrl_unchanged", {16'b0, uart_control}, 32'h3C50);
        chk("oor_baud_unchanged", baudrate, 32'h5678_0006);
        rd_chk("oor_rd_40", 8'h40, 32'h0);
        rd_chk("oor_rd_info", 8'h5C, 32'h0);

        // ---- back-to-back reads ----
        @(negedge clk);
        rsel = 1'b1; rwrite = 1'b0; addr = 8'h1C; rsize = 2'd0;
        @(posedge clk); #1;
        chk("b2b_first", rdata, 32'h0000_0200);
        addr = 8'h3C;
        @(posedge clk); #1;
        rsel = 1'b0;
        chk("b2b_second", rdata, 32'h0000_0201);
        chk("b2b_second_rvalid", {31'b0, rvalid}, 32'h1);
        @(posedge clk); #1;
        chk("b2b_idle_rvalid", {31'b0, rvalid}, 32'h0);
        chk("b2b_rdata_held", rdata, 32'h0000_0201);

        // ---- reset mid-transfer ----
        bus_write(8'h14, 2'd0, 32'h55);
        chk("pre_rst_tx_valid", {30'b0, tx_valid}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0; rsel = 1'b1; rwrite = 1'b0; addr = 8'h00;
        @(posedge clk); #1;
        rsel = 1'b0;
        chk("midrst_tx_valid", {30'b0, tx_valid}, 32'h0);
        chk("midrst_rvalid",   {31'b0, rvalid}, 32'h0);
        chk("midrst_ctrl",     {16'b0, uart_control}, 32'h5050);
        chk("midrst_baud",     baudrate, 32'h0006_0006);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_rvalid", {31'b0, rvalid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
